muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide engine that replaces the separate fixed 32-bit multiplier and divider next to the HI/LO registers.
- Supports four operations: signed and unsigned multiply, signed and unsigned divide.
- Uses one shared shift/add datapath.
- Uses a start/ready handshake toward the control unit and flags divide-by-zero.
- Results are presented as hi/lo words for direct loading into HI_reg/LO_reg.

Parameters:
WIDTH, 32, operand width in bits (≥4, even); hi/lo are each WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
a  in  WIDTH  multiplicand / dividend (from A register)
b  in  WIDTH  multiplier / divisor (from B register)
busy  out  1  high from the edge that accepts start until the edge ready rises
ready  out  1  one-cycle completion pulse
div_zero  out  1  high with ready when a divide had b==0; held until next accepted start
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; busy=0, ready=0, div_zero=0, hi=0, lo=0; counter=0.
  - Reset asserted mid-operation aborts it; no ready pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch op, |a|, |b| (magnitudes only for signed ops) and the result signs; counter=WIDTH; busy=1; div_zero cleared.
  - Divide with b==0: go directly to DONE, set div_zero=1, leave hi/lo unchanged.
  - Otherwise go to CALC.
- CALC: one iteration per cycle; counter decrements; move to FIX when the counter reaches 0 (exactly WIDTH cycles in CALC).
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bit=1 when the partial remainder is ≥ divisor.
- FIX: apply signs for signed ops.
  - Product is negated when sign(a)^sign(b).
  - Quotient is negated when sign(a)^sign(b); remainder takes sign(a). Quotient truncates toward zero.
  - Load hi/lo.
- DONE: ready=1 for exactly one cycle; busy=0 in the same cycle; next state IDLE.
- Latency: ready is high in the cycle after edge N+WIDTH+2, where edge N accepted start. Divide-by-zero: ready is high after edge N+1.
- hi/lo hold their value from ready until the FIX state of the next operation; they do not change during CALC.
- start while busy (CALC/FIX/DONE) is ignored; not queued.
- a/b/op changes after acceptance have no effect.
- Signed DIV of most-negative by −1: lo=most-negative (2^(WIDTH−1)), hi=0; no flag.
- Signed MULT of most-negative × most-negative: hi:lo=2^(2*WIDTH−2), exact.
- All arithmetic is modulo the stated widths. No overflow output.

Optional Feature:
MULDIV_EARLY_OUT_EN
- When defined:
  - In CALC for multiply, if the remaining unshifted multiplier bits are all zero, go directly to FIX. The accumulator is shifted to its final alignment in that cycle.
  - Multiply latency = (index of highest set bit of |b|)+1 CALC cycles, minimum 1.
  - b==0 multiply takes 1 CALC cycle and yields hi=lo=0.
  - Divide timing is unchanged.
- When not defined: every non-div-zero operation takes exactly WIDTH CALC cycles. Results are identical either way.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, ready exactly 34 edges after the start edge, busy high throughout.
2. MULT a=−7 (0xFFFFFFF9) b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6 (−42). DIV a=−7 b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100 b=7 → lo=14, hi=2.
3. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0. DIV/DIVU with b=0 → ready after 1 edge, div_zero=1, hi/lo keep their prior values; the next accepted start clears div_zero.
4. start re-pulsed on cycles 5 and 20 of an active op with different operands → ignored; exactly one ready; result matches the first operands.
5. reset asserted on cycle 10 of CALC → next cycle busy=0, hi=lo=0, no ready pulse; a fresh MULTU 3×5 then yields lo=15, hi=0.
6. WIDTH=8 parameter: MULT a=0x80 b=0x80 → hi=0x40, lo=0x00, ready after 10 edges. With MULDIV_EARLY_OUT_EN: MULTU WIDTH=32 a=9 b=3 → lo=27, ready after 4 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide engine built on
// one shared shift/add datapath. Results come out as hi/lo words ready for
// loading into HI/LO.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
// finishes CALC as soon as the remaining multiplier bits are all zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q;
  logic               busy_q;
  logic               ready_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_res_q;   // negate product / quotient
  logic               neg_rem_q;   // negate remainder (sign of dividend)
  logic [WIDTH-1:0]   opnd_q;      // |a| for multiply, |b| for divide
  logic [2*WIDTH-1:0] acc_q;       // multiply: {partial, multiplier}; divide: {remainder, quotient}

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH+1:0]   add_x;
  logic [WIDTH+1:0]   add_y;
  logic [WIDTH+1:0]   sum;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] acc_d;

  logic               last_iter;
  logic [2*WIDTH-1:0] acc_last;

  // Operand conditioning: signed ops work on magnitudes, signs are reapplied in FIX
  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  // Shared adder: multiply adds |a| into the upper half, divide trial-subtracts |b|
  always_comb begin
    if (is_div_q) begin
      // Upper half shifted left by one with the next dividend bit brought in
      add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]};
      add_y = ~{2'b00, opnd_q};
    end else begin
      add_x = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
      add_y = acc_q[0] ? {2'b00, opnd_q} : '0;
    end
    sum      = add_x + add_y + {{(WIDTH+1){1'b0}}, is_div_q};
    // Non-negative difference means partial remainder >= divisor
    q_bit    = ~sum[WIDTH+1];
    rem_next = q_bit ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
    if (is_div_q) begin
      acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
    end else begin
      acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] rest_cnt;
  logic [WIDTH-1:0] rest_mask;

  // Early exit when no multiplier bits remain; the pending shifts are applied at once
  always_comb begin
    rest_cnt  = cnt_q - CNT_W'(1);
    rest_mask = ~({WIDTH{1'b1}} << rest_cnt);
    last_iter = (cnt_q == CNT_W'(1)) ||
                (!is_div_q && (((acc_q[WIDTH-1:0] >> 1) & rest_mask) == '0));
    acc_last  = is_div_q ? acc_d : (acc_d >> rest_cnt);
  end
`else
  // Every operation runs the full WIDTH iterations
  always_comb begin
    last_iter = (cnt_q == CNT_W'(1));
    acc_last  = acc_d;
  end
`endif

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div_q   <= op[1];
            neg_res_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q  <= op_signed & a[WIDTH-1];
            cnt_q      <= CNT_W'(WIDTH);
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            if (op[1]) begin
              opnd_q <= b_mag;
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
            end
            // A zero divisor skips the datapath entirely
            state_q <= (op[1] && (b == '0)) ? DONE : CALC;
          end
        end
        CALC: begin
          acc_q <= acc_last;
          if (last_iter) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          if (is_div_q) begin
            lo_q <= neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_q <= neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_q, lo_q} <= neg_res_q ? -acc_q : acc_q;
          end
          state_q <= DONE;
        end
        DONE: begin
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          // opnd_q holds |b| for a divide, so zero here means divide-by-zero
          div_zero_q <= is_div_q && (opnd_q == '0);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
